// File: rtl/decode_stage_if.sv
// Handshake and data bundle between the decode stage and its neighbours (fetch, regfile,
// EXE/MEM/WB hazard taps). The slave modport is the decode stage itself.
interface decode_stage_if #(
  parameter int unsigned STALL_CNT_W = 32
);
  logic                   IF_over;
  logic [63:0]            IF_ID_bus;
  logic                   ID_allow_in;
  logic                   EXE_allow_in;
  logic                   cancel;
  logic [4:0]             rs_addr;
  logic [4:0]             rt_addr;
  logic [31:0]            rs_value;
  logic [31:0]            rt_value;
  logic [4:0]             EXE_wdest;
  logic [4:0]             MEM_wdest;
  logic [4:0]             WB_wdest;
  logic                   ID_over;
  logic [132:0]           ID_EXE_bus;
  logic [32:0]            jbr_bus;
  logic [STALL_CNT_W-1:0] stall_cnt;
  logic [31:0]            ID_pc;

  modport master (
    output IF_over, IF_ID_bus, EXE_allow_in, cancel, rs_value, rt_value,
           EXE_wdest, MEM_wdest, WB_wdest,
    input  ID_allow_in, rs_addr, rt_addr, ID_over, ID_EXE_bus, jbr_bus, stall_cnt, ID_pc
  );

  modport slave (
    input  IF_over, IF_ID_bus, EXE_allow_in, cancel, rs_value, rt_value,
           EXE_wdest, MEM_wdest, WB_wdest,
    output ID_allow_in, rs_addr, rt_addr, ID_over, ID_EXE_bus, jbr_bus, stall_cnt, ID_pc
  );
endinterface

// File: rtl/decode_stage.sv
// MIPS decode stage: holds the fetched {pc, inst}, decodes it, resolves branches/jumps
// and interlocks on RAW hazards (no forwarding) before handing the bundle to EXE.
module decode_stage #(
  parameter int unsigned STALL_CNT_W = 32
) (
  input logic         clk,
  input logic         resetn,
  decode_stage_if.slave bus
);

  logic                   id_valid_q;
  logic [31:0]            pc_q;
  logic [31:0]            inst_q;
  logic [STALL_CNT_W-1:0] stall_cnt_q;

  logic                   id_allow_in;
  logic                   id_over;
  logic                   hazard;

  logic [5:0] op;
  logic [4:0] rs;
  logic [4:0] rt;
  logic [4:0] rd;
  logic [5:0] funct;

  assign op    = inst_q[31:26];
  assign rs    = inst_q[25:21];
  assign rt    = inst_q[20:16];
  assign rd    = inst_q[15:11];
  assign funct = inst_q[5:0];

  // Instruction class decode
  logic r_alu, shift_imm, is_jr, is_jalr, i_alu, is_load, is_store;
  logic is_beq, is_bne, is_bgez, is_bgtz, is_blez, is_bltz, is_j, is_jal;

  always_comb begin
    r_alu     = 1'b0;
    shift_imm = 1'b0;
    is_jr     = 1'b0;
    is_jalr   = 1'b0;
    i_alu     = 1'b0;
    is_load   = 1'b0;
    is_store  = 1'b0;
    is_beq    = 1'b0;
    is_bne    = 1'b0;
    is_bgez   = 1'b0;
    is_bgtz   = 1'b0;
    is_blez   = 1'b0;
    is_bltz   = 1'b0;
    is_j      = 1'b0;
    is_jal    = 1'b0;
    case (op)
      6'b000000: begin
        case (funct)
          6'b000000, 6'b000010, 6'b000011: begin
            r_alu     = 1'b1;
            shift_imm = 1'b1;
          end
          6'b000100, 6'b000110, 6'b000111,
          6'b100000, 6'b100001, 6'b100010, 6'b100011,
          6'b100100, 6'b100101, 6'b100110, 6'b100111,
          6'b101010, 6'b101011: r_alu = 1'b1;
          6'b001000: is_jr = 1'b1;
          6'b001001: is_jalr = 1'b1;
          default: ;
        endcase
      end
      6'b000001: begin
        case (rt)
          5'b00001: is_bgez = 1'b1;
          5'b00000: is_bltz = 1'b1;
          default: ;
        endcase
      end
      6'b000010: is_j    = 1'b1;
      6'b000011: is_jal  = 1'b1;
      6'b000100: is_beq  = 1'b1;
      6'b000101: is_bne  = 1'b1;
      6'b000110: is_blez = 1'b1;
      6'b000111: is_bgtz = 1'b1;
      6'b001000, 6'b001001, 6'b001010, 6'b001011,
      6'b001100, 6'b001101, 6'b001110, 6'b001111: i_alu = 1'b1;
      6'b100000, 6'b100001, 6'b100011, 6'b100100, 6'b100101: is_load = 1'b1;
      6'b101000, 6'b101001, 6'b101011: is_store = 1'b1;
      default: ;
    endcase
  end

  logic rs_used, rt_used;
  assign rs_used = (r_alu & ~shift_imm) | i_alu | is_load | is_store | is_beq | is_bne |
                   is_bgez | is_bgtz | is_blez | is_bltz | is_jr | is_jalr;
  assign rt_used = r_alu | is_store | is_beq | is_bne;

  logic [4:0] wdest;
  always_comb begin
    wdest = 5'd0;
    if (is_jal)                wdest = 5'd31;
    else if (is_jalr | r_alu)  wdest = rd;
    else if (i_alu | is_load)  wdest = rt;
  end

  // Register 0 is never a real producer, so it can never stall
  logic rs_hit, rt_hit;
  assign rs_hit = rs_used & (rs != 5'd0) &
                  ((rs == bus.EXE_wdest) | (rs == bus.MEM_wdest) | (rs == bus.WB_wdest));
  assign rt_hit = rt_used & (rt != 5'd0) &
                  ((rt == bus.EXE_wdest) | (rt == bus.MEM_wdest) | (rt == bus.WB_wdest));
  assign hazard = id_valid_q & (rs_hit | rt_hit);

  assign id_over     = id_valid_q & ~hazard & ~bus.cancel;
  assign id_allow_in = ~id_valid_q | (id_over & bus.EXE_allow_in);

  // Branch / jump resolution
  logic [31:0] bd_pc, br_target, j_target, target;
  logic        rs_eq_rt, rs_neg, rs_zero, taken, jbr_taken;

  assign bd_pc     = pc_q + 32'd4;
  assign br_target = bd_pc + {{14{inst_q[15]}}, inst_q[15:0], 2'b00};
  assign j_target  = {bd_pc[31:28], inst_q[25:0], 2'b00};
  assign rs_eq_rt  = bus.rs_value == bus.rt_value;
  assign rs_neg    = bus.rs_value[31];
  assign rs_zero   = bus.rs_value == 32'd0;

  assign taken = (is_beq & rs_eq_rt) | (is_bne & ~rs_eq_rt) | (is_bgez & ~rs_neg) |
                 (is_bgtz & ~rs_neg & ~rs_zero) | (is_blez & (rs_neg | rs_zero)) |
                 (is_bltz & rs_neg) | is_j | is_jal | is_jr | is_jalr;

  always_comb begin
    target = br_target;
    if (is_j | is_jal)         target = j_target;
    else if (is_jr | is_jalr)  target = bus.rs_value;
  end

  // Redirect only on the cycle the control instruction leaves, so fetch sees one pulse
  assign jbr_taken = taken & id_over & bus.EXE_allow_in;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      id_valid_q  <= 1'b0;
      pc_q        <= 32'd0;
      inst_q      <= 32'd0;
      stall_cnt_q <= '0;
    end else begin
      if (bus.cancel)       id_valid_q <= 1'b0;
      else if (id_allow_in) id_valid_q <= bus.IF_over;
      if (bus.IF_over & id_allow_in & ~bus.cancel) begin
        pc_q   <= bus.IF_ID_bus[63:32];
        inst_q <= bus.IF_ID_bus[31:0];
      end
      if (hazard & ~bus.cancel) stall_cnt_q <= stall_cnt_q + STALL_CNT_W'(1);
    end
  end

  assign bus.ID_allow_in = id_allow_in;
  assign bus.ID_over     = id_over;
  assign bus.rs_addr     = rs;
  assign bus.rt_addr     = rt;
  assign bus.ID_EXE_bus  = {pc_q, inst_q, bus.rs_value, bus.rt_value, wdest};
  assign bus.jbr_bus     = {jbr_taken, jbr_taken ? target : 32'd0};
  assign bus.stall_cnt   = stall_cnt_q;
  assign bus.ID_pc       = pc_q;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: expected EXE bundles and redirects are queued when a
// fetch bundle is driven and compared when the bundle leaves ID.
module tb_decode_stage;
  localparam int unsigned W = 32;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  decode_stage_if #(.STALL_CNT_W(W)) bus ();
  decode_stage #(.STALL_CNT_W(W)) dut (.clk(clk), .resetn(resetn), .bus(bus));

  typedef struct packed {
    logic [132:0] ex;
    logic [32:0]  jbr;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string tag, input logic [132:0] got, input logic [132:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Output monitor: every departure must match the head of the scoreboard, and the
  // redirect bus must be quiet on every other cycle.
  always @(negedge clk) begin
    exp_t e;
    if (resetn) begin
      if (bus.ID_over && bus.EXE_allow_in) begin
        if (sb.size() == 0) check("unexpected_out", 133'(1), 133'(0));
        else begin
          e = sb.pop_front();
          check("id_exe_bus", bus.ID_EXE_bus, e.ex);
          check("jbr_bus", 133'(bus.jbr_bus), 133'(e.jbr));
        end
      end else begin
        check("jbr_idle", 133'(bus.jbr_bus), 133'(0));
      end
    end
  end

  task automatic drive_in(input logic [31:0] pc, input logic [31:0] inst,
                          input logic [31:0] rsv, input logic [31:0] rtv,
                          input logic [4:0] wd, input logic [32:0] jbr);
    int guard;
    guard = 0;
    while (!(bus.ID_allow_in && !bus.ID_over) && guard < 50) begin
      step();
      guard++;
    end
    if (guard >= 50) check("drive_timeout", 133'(1), 133'(0));
    bus.rs_value  = rsv;
    bus.rt_value  = rtv;
    bus.IF_ID_bus = {pc, inst};
    bus.IF_over   = 1'b1;
    sb.push_back({{pc, inst, rsv, rtv, wd}, jbr});
    step();
    bus.IF_over = 1'b0;
  endtask

  task automatic wait_drain();
    int guard;
    guard = 0;
    while (sb.size() != 0 && guard < 50) begin
      step();
      guard++;
    end
    check("drain", 133'(sb.size()), 133'(0));
  endtask

  task automatic run(input logic [31:0] pc, input logic [31:0] inst,
                     input logic [31:0] rsv, input logic [31:0] rtv,
                     input logic [4:0] wd, input logic [32:0] jbr);
    drive_in(pc, inst, rsv, rtv, wd, jbr);
    wait_drain();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout got 0 exp 1");
    $fatal(1);
  end

  initial begin
    resetn           = 1'b0;
    bus.IF_over      = 1'b0;
    bus.IF_ID_bus    = '0;
    bus.EXE_allow_in = 1'b1;
    bus.cancel       = 1'b0;
    bus.rs_value     = '0;
    bus.rt_value     = '0;
    bus.EXE_wdest    = '0;
    bus.MEM_wdest    = '0;
    bus.WB_wdest     = '0;
    step();
    step();
    check("rst_allow_in", 133'(bus.ID_allow_in), 133'(1));
    check("rst_over", 133'(bus.ID_over), 133'(0));
    check("rst_jbr", 133'(bus.jbr_bus), 133'(0));
    resetn = 1'b1;
    step();
    check("post_rst_allow_in", 133'(bus.ID_allow_in), 133'(1));
    check("post_rst_over", 133'(bus.ID_over), 133'(0));
    check("post_rst_jbr", 133'(bus.jbr_bus), 133'(0));
    check("post_rst_stall", 133'(bus.stall_cnt), 133'(0));

    // Branches and jumps
    drive_in(32'h0000_0034, 32'h1022_0003, 32'd5, 32'd5, 5'd0, {1'b1, 32'h0000_0044});
    check("id_pc", 133'(bus.ID_pc), 133'(32'h34));
    wait_drain();
    run(32'h0000_0034, 32'h1022_0003, 32'd5, 32'd6, 5'd0, 33'h0);
    run(32'h1000_0040, 32'h0800_0010, 32'd0, 32'd0, 5'd0, {1'b1, 32'h1000_0040});
    run(32'h1000_0040, 32'h0C00_0010, 32'd0, 32'd0, 5'd31, {1'b1, 32'h1000_0040});
    run(32'h0000_0200, 32'h0421_0010, 32'h8000_0000, 32'd0, 5'd0, 33'h0);
    run(32'h0000_0200, 32'h1820_0010, 32'd0, 32'd0, 5'd0, {1'b1, 32'h0000_0244});
    run(32'h0000_0200, 32'h1C20_0010, 32'd0, 32'd0, 5'd0, 33'h0);
    run(32'h0000_0200, 32'h0420_0010, 32'hFFFF_FFFF, 32'd0, 5'd0, {1'b1, 32'h0000_0244});
    run(32'h0000_0300, 32'h0020_0008, 32'h0040_0000, 32'd0, 5'd0, {1'b1, 32'h0040_0000});
    run(32'h0000_0300, 32'h0100_F809, 32'h0040_0020, 32'd0, 5'd31, {1'b1, 32'h0040_0020});
    run(32'hFFFF_FFF8, 32'h1022_0001, 32'd7, 32'd7, 5'd0, {1'b1, 32'h0000_0000});
    // Non-control classes, including an undecodable opcode
    run(32'h0000_0310, 32'h8C22_0004, 32'd1, 32'd2, 5'd2, 33'h0);
    run(32'h0000_0314, 32'hAC22_0004, 32'd1, 32'd2, 5'd0, 33'h0);
    run(32'h0000_0318, 32'h0002_1880, 32'd0, 32'd9, 5'd3, 33'h0);
    run(32'h0000_031C, 32'hFC00_0000, 32'd0, 32'd0, 5'd0, 33'h0);

    // RAW hazard walking EXE -> MEM -> WB
    bus.EXE_wdest = 5'd3;
    drive_in(32'h0000_0400, 32'h0064_2821, 32'd11, 32'd22, 5'd5, 33'h0);
    check("haz_over_c1", 133'(bus.ID_over), 133'(0));
    check("haz_allow_c1", 133'(bus.ID_allow_in), 133'(0));
    check("rs_addr", 133'(bus.rs_addr), 133'(3));
    check("rt_addr", 133'(bus.rt_addr), 133'(4));
    step();
    bus.EXE_wdest = 5'd0;
    bus.MEM_wdest = 5'd3;
    #1;
    check("haz_over_c2", 133'(bus.ID_over), 133'(0));
    step();
    bus.MEM_wdest = 5'd0;
    bus.WB_wdest  = 5'd3;
    #1;
    check("haz_over_c3", 133'(bus.ID_over), 133'(0));
    step();
    bus.WB_wdest = 5'd0;
    #1;
    check("haz_over_c4", 133'(bus.ID_over), 133'(1));
    check("stall_cnt_3", 133'(bus.stall_cnt), 133'(3));
    wait_drain();

    // rs = 0 never stalls
    drive_in(32'h0000_0500, 32'h2401_0005, 32'h99, 32'd0, 5'd1, 33'h0);
    check("rs0_over", 133'(bus.ID_over), 133'(1));
    wait_drain();

    // BNE held by EXE back-pressure: redirect only once it leaves
    bus.EXE_allow_in = 1'b0;
    drive_in(32'h0000_0100, 32'h1422_FFFF, 32'd1, 32'd2, 5'd0, {1'b1, 32'h0000_0100});
    check("bne_hold_jbr1", 133'(bus.jbr_bus), 133'(0));
    check("bne_hold_over", 133'(bus.ID_over), 133'(1));
    step();
    check("bne_hold_jbr2", 133'(bus.jbr_bus), 133'(0));
    check("bne_hold_allow", 133'(bus.ID_allow_in), 133'(0));
    step();
    bus.EXE_allow_in = 1'b1;
    wait_drain();

    // Cancel while stalled, with a new bundle offered in the same cycle
    bus.EXE_wdest = 5'd3;
    bus.IF_ID_bus = {32'h0000_0600, 32'h0064_2821};
    bus.IF_over   = 1'b1;
    step();
    bus.IF_over = 1'b0;
    check("cxl_stalled", 133'(bus.ID_over), 133'(0));
    step();
    check("cxl_stall_cnt_pre", 133'(bus.stall_cnt), 133'(4));
    bus.cancel    = 1'b1;
    bus.IF_over   = 1'b1;
    bus.IF_ID_bus = {32'h0000_0700, 32'h2401_0005};
    #1;
    check("cxl_over", 133'(bus.ID_over), 133'(0));
    check("cxl_jbr", 133'(bus.jbr_bus), 133'(0));
    step();
    bus.cancel  = 1'b0;
    bus.IF_over = 1'b0;
    #1;
    check("cxl_after_over", 133'(bus.ID_over), 133'(0));
    check("cxl_after_allow", 133'(bus.ID_allow_in), 133'(1));
    check("cxl_pc_kept", 133'(bus.ID_pc), 133'(32'h600));
    check("cxl_stall_cnt", 133'(bus.stall_cnt), 133'(4));
    step();
    check("cxl_stall_cnt2", 133'(bus.stall_cnt), 133'(4));
    bus.EXE_wdest = 5'd0;
    step();
    wait_drain();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
